ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter. Sends command bytes (LED set 0xED, reset 0xFF,

---
 rtl/ps2_host_tx.sv | 164 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: open-drain PS/2 host-to-device byte transmitter with ACK check and watchdog.
// Optional PS2_TX_RETRY_EN: one silent retry of the same byte after a NACK or timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_DV,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic       o_rx_inhibit,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe
);
    localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, RELEASE} state_t;
    state_t state, state_n;
    logic [1:0] clk_sync, data_sync;
    logic clk_prev, fall;
    logic [9:0] shreg, shreg_n;
    logic [CW-1:0] cnt, cnt_n, wd, wd_n;
    logic [3:0] edges, edges_n;
    logic nack, nack_n;
    logic clk_oe_n, data_oe_n, busy_n, done_n, error_n;
    logic wd_on, timeout, finish, fail, can_retry;

    assign fall = clk_prev & ~clk_sync[1];
    assign o_rx_inhibit = o_busy;
    // The watchdog only runs once the clock line has been handed to the device.
    assign wd_on = (state == REQ && !o_ps2_clk_oe) || state == SHIFT || state == ACK;
    assign timeout = wd_on && wd == TO_LAST;
    assign finish = state == RELEASE && clk_sync[1] && data_sync[1];
    assign fail = timeout || (finish && nack);

`ifdef PS2_TX_RETRY_EN
    logic retried;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || state == IDLE)
            retried <= 1'b0;
        else if (fail)
            retried <= 1'b1;
    end
    assign can_retry = ~retried;
`else
    assign can_retry = 1'b0;
`endif

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n = cnt;
        wd_n = (wd_on && wd != CNT_MAX) ? wd + CW'(1) : wd;
        edges_n = edges;
        nack_n = nack;
        clk_oe_n = o_ps2_clk_oe;
        data_oe_n = o_ps2_data_oe;
        busy_n = o_busy;
        done_n = 1'b0;
        error_n = 1'b0;
        case (state)
            IDLE: begin
                busy_n = 1'b0;
                clk_oe_n = 1'b0;
                data_oe_n = 1'b0;
                // o_busy is still high on the o_done cycle, which blocks a same-cycle restart.
                if (i_DV && !o_busy) begin
                    shreg_n = {1'b1, ~^i_data, i_data};
                    cnt_n = '0;
                    nack_n = 1'b0;
                    busy_n = 1'b1;
                    clk_oe_n = 1'b1;
                    state_n = INHIBIT;
                end
            end
            INHIBIT: begin
                cnt_n = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
                if (cnt == INH_LAST) begin
                    data_oe_n = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (o_ps2_clk_oe) begin
                    clk_oe_n = 1'b0;
                    wd_n = '0;
                end else if (fall) begin
                    data_oe_n = ~shreg[0];
                    edges_n = 4'd1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (fall) begin
                    data_oe_n = ~shreg[edges];
                    edges_n = edges + 4'd1;
                    state_n = (edges == 4'd9) ? ACK : SHIFT;
                end
            end
            ACK: begin
                if (fall) begin
                    nack_n = data_sync[1];
                    state_n = RELEASE;
                end
            end
            default: ;
        endcase
        if (timeout || finish) begin
            clk_oe_n = 1'b0;
            data_oe_n = 1'b0;
            if (fail && can_retry) begin
                cnt_n = '0;
                clk_oe_n = 1'b1;
                state_n = INHIBIT;
            end else begin
                done_n = 1'b1;
                error_n = fail;
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            clk_sync <= 2'b11;
            data_sync <= 2'b11;
            clk_prev <= 1'b1;
            state <= IDLE;
            shreg <= '0;
            cnt <= '0;
            wd <= '0;
            edges <= '0;
            nack <= 1'b0;
            o_ps2_clk_oe <= 1'b0;
            o_ps2_data_oe <= 1'b0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_error <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], i_ps2_clk};
            data_sync <= {data_sync[0], i_ps2_data};
            clk_prev <= clk_sync[1];
            state <= state_n;
            shreg <= shreg_n;
            cnt <= cnt_n;
            wd <= wd_n;
            edges <= edges_n;
            nack <= nack_n;
            o_ps2_clk_oe <= clk_oe_n;
            o_ps2_data_oe <= data_oe_n;
            o_busy <= busy_n;
            o_done <= done_n;
            o_error <= error_n;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a simple PS/2 device model on open-drain lines.
module tb_ps2_host_tx;
    localparam int INH = 50;
    localparam int TO = 4000;
    localparam int HALF = 100;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dv = 1'b0;
    logic [7:0] data = 8'h00;
    logic busy, done, error, rx_inh, clk_oe, data_oe;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk, ps2_data;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int inh_starts = 0;
    logic done_err = 1'b0;
    logic busy_after = 1'b0;
    logic done_prev = 1'b0;
    logic [1:0] prev_oe = 2'b00;
    logic [1:0] done_oe = 2'b00;
    logic [1:0] pre_oe = 2'b00;

    assign ps2_clk = clk_oe ? 1'b0 : dev_clk;
    assign ps2_data = data_oe ? 1'b0 : dev_data;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_DV(dv),
        .o_busy(busy), .o_done(done), .o_error(error), .o_rx_inhibit(rx_inh),
        .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
        .o_ps2_clk_oe(clk_oe), .o_ps2_data_oe(data_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_oe <= {clk_oe, data_oe};
        done_prev <= done;
        if (done_prev) busy_after <= busy;
        if (clk_oe && !prev_oe[1]) inh_starts <= inh_starts + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_err <= error;
            done_cyc <= cyc;
            done_oe <= {clk_oe, data_oe};
            pre_oe <= prev_oe;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [7:0] b);
        data = b;
        dv = 1'b1;
        tick();
        dv = 1'b0;
    endtask

    task automatic run_start(input string tag, output int rel);
        int n = 0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_rx_inhibit"}, rx_inh, 1);
        while (clk_oe && !data_oe && n < INH + 10) begin
            n++;
            tick();
        end
        chk({tag, "_inhibit_len"}, n, INH);
        chk({tag, "_start_bit"}, {clk_oe, data_oe}, 2'b11);
        tick();
        chk({tag, "_release"}, {clk_oe, data_oe}, 2'b01);
        rel = cyc;
    endtask

    task automatic device(input logic ack, input int nclk, input int dv_at, output logic [10:0] got);
        int t = 0;
        got = '0;
        while (!(ps2_clk && !ps2_data) && t < 200) begin
            t++;
            tick();
        end
        repeat (HALF) tick();
        for (int i = 0; i < nclk; i++) begin
            dev_clk = 1'b0;
            if (i + 1 == dv_at) begin
                tick();
                data = 8'h55;
                dv = 1'b1;
                tick();
                dv = 1'b0;
                repeat (HALF - 2) tick();
            end else begin
                repeat (HALF) tick();
            end
            dev_clk = 1'b1;
            got[i] = ps2_data;
            if (ack && i == 9) dev_data = 1'b0;
            repeat (HALF) tick();
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int prev);
        int t = 0;
        while (done_cnt == prev && t < TO + 200) begin
            t++;
            tick();
        end
        chk({tag, "_done"}, done_cnt, prev + 1);
        tick();
    endtask

    initial begin
        int rel, d0, i0, t;
        logic [10:0] got;
        repeat (3) tick();
        chk("reset_outputs", {busy, done, error, rx_inh, clk_oe, data_oe}, 6'b0);
        rst_n = 1'b1;
        repeat (5) tick();
        // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1, ACK low
        d0 = done_cnt;
        start(8'hED);
        run_start("t1", rel);
        device(1'b1, 11, 0, got);
        chk("t1_frame", got, 11'h3ED);
        chk("t1_parity", got[8], 1'b1);
        wait_done("t1", d0);
        chk("t1_error", done_err, 1'b0);
        chk("t1_busy_after", busy_after, 1'b0);
        d0 = done_cnt;
        start(8'h01);
        run_start("t2a", rel);
        device(1'b1, 11, 0, got);
        chk("t2a_frame", got, 11'h201);
        wait_done("t2a", d0);
        chk("t2a_error", done_err, 1'b0);
        chk("t2a_busy_after", busy_after, 1'b0);
        d0 = done_cnt;
        start(8'hFF);
        run_start("t2b", rel);
        device(1'b1, 11, 0, got);
        chk("t2b_frame", got, 11'h3FF);
        wait_done("t2b", d0);
        chk("t2b_error", done_err, 1'b0);
        chk("t2b_busy_after", busy_after, 1'b0);
        // NACK: data left high on the 11th clock
        d0 = done_cnt;
        i0 = inh_starts;
        start(8'hF4);
        run_start("t3", rel);
        device(1'b0, 11, 0, got);
        chk("t3_frame", got, 11'h6F4);
`ifdef PS2_TX_RETRY_EN
        chk("t3_retry_inhibit", inh_starts, i0 + 2);
        chk("t3_no_early_done", done_cnt, d0);
        device(1'b0, 11, 0, got);
        chk("t3_retry_frame", got, 11'h6F4);
`endif
        wait_done("t3", d0);
        chk("t3_error", done_err, 1'b1);
        // Silent device: watchdog fires TO cycles after the clock release
        d0 = done_cnt;
        start(8'hF2);
        run_start("t4", rel);
`ifdef PS2_TX_RETRY_EN
        t = 0;
        while (!clk_oe && t < TO + 100) begin
            t++;
            tick();
        end
        chk("t4_retry_no_done", done_cnt, d0);
        run_start("t4r", rel);
`endif
        wait_done("t4", d0);
        chk("t4_error", done_err, 1'b1);
        chk("t4_latency", done_cyc - rel, TO);
        chk("t4_oe_at_done", done_oe, 2'b00);
        chk("t4_oe_before_done", pre_oe, 2'b01);
        // i_DV with 0x55 at edge 4 of a 0xEE frame is ignored
        d0 = done_cnt;
        start(8'hEE);
        run_start("t5", rel);
        i0 = inh_starts;
        device(1'b1, 11, 4, got);
        chk("t5_frame", got, 11'h3EE);
        wait_done("t5", d0);
        chk("t5_error", done_err, 1'b0);
        repeat (300) tick();
        chk("t5_no_second_frame", inh_starts, i0);
        chk("t5_single_done", done_cnt, d0 + 1);
        chk("t5_idle", {busy, clk_oe, data_oe}, 3'b000);
        // Reset after edge 6 aborts the frame without o_done
        d0 = done_cnt;
        start(8'h12);
        run_start("t6", rel);
        device(1'b1, 6, 0, got);
        chk("t6_mid_frame_busy", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("t6_reset_release", {clk_oe, data_oe, busy, done}, 4'b0000);
        rst_n = 1'b1;
        repeat (300) tick();
        chk("t6_no_done", done_cnt, d0);
        start(8'hA5);
        run_start("t6n", rel);
        device(1'b1, 11, 0, got);
        chk("t6n_frame", got, 11'h3A5);
        wait_done("t6n", d0);
        chk("t6n_error", done_err, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
